// File: rtl/cci_mpf_rd_arb_pkg.sv
// Shared types and constants for the MPF c0 read-request arbiter.
// Holds the client index and credit counter types, the Mdata field layout
// and the position of the bits reserved for MPF internal use.
package cci_mpf_rd_arb_pkg;

    localparam int unsigned MAX_N_CLIENTS    = 8;
    localparam int unsigned CLIENT_IDX_MAX_W = 3;
    localparam int unsigned MAX_ACTIVE_REQS  = 128;
    localparam int unsigned CREDIT_W         = 8;

    // Mdata layout: {reserved[15:14], zero pad, client mdata, client idx}
    localparam int unsigned MDATA_W        = 16;
    localparam int unsigned MDATA_IDX_LSB  = 0;
    localparam int unsigned MDATA_RSVD_LSB = 14;

    typedef logic [CLIENT_IDX_MAX_W-1:0] client_idx_t;
    typedef logic [CREDIT_W-1:0]         credit_t;
    typedef logic [MDATA_W-1:0]          mdata_t;

endpackage

// File: rtl/cci_mpf_rr_arbiter.sv
// Rotating-priority N-way arbiter.
// Ports:
//   clk, reset   clock, async active-high reset
//   req_i        eligible requesters
//   grant_o      one-hot combinational grant
//   win_o        index of the granted requester
//   win_valid_o  a grant was issued this cycle
// The search starts one past the last granted requester; the pointer only
// moves when a grant is issued and resets so that requester 0 wins first.
module cci_mpf_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] win_o,
    output logic                 win_valid_o
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] pos;

    // Combinational pick: first requester after last_q, wrapping modulo N
    always_comb begin
        grant_o     = '0;
        win_o       = last_q;
        win_valid_o = 1'b0;
        pos         = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            pos = IDX_W'((32'(last_q) + off) % N);
            if (!win_valid_o && req_i[pos]) begin
                grant_o[pos] = 1'b1;
                win_o        = pos;
                win_valid_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= IDX_W'(N - 1);
        end else if (win_valid_o) begin
            last_q <= win_o;
        end
    end

endmodule

// File: rtl/cci_mpf_rd_arb.sv
// Shares the MPF c0 read request channel among N_CLIENTS requesters.
// Round-robin grant limited by per-client outstanding-read credits and FIU
// almost-full; the client index is packed into the low Mdata bits and used
// to steer EOP-tagged responses back to the owner.
// Ports:
//   clk, reset                          clock, async active-high reset
//   cl_req_valid/addr/mdata             per-client request
//   cl_req_grant                        one-hot same-cycle acceptance
//   mpf_c0_req_valid/addr/mdata         registered request to MPF
//   mpf_c0_almost_full                  MPF backpressure
//   mpf_c0_rsp_valid/eop/mdata          response beats from MPF
//   cl_rsp_valid, cl_rsp_mdata          combinational response steer
//   err_credit_underflow                sticky error flag
// Optional: CCI_MPF_RD_ARB_STATS_EN adds stat_grants and stat_af_stall.
module cci_mpf_rd_arb
    import cci_mpf_rd_arb_pkg::*;
#(
    parameter int unsigned N_CLIENTS             = 4,
    parameter int unsigned MAX_ACTIVE_PER_CLIENT = 32,
    parameter int unsigned ADDR_WIDTH            = 42,
    parameter int unsigned CLIENT_MDATA_WIDTH    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [N_CLIENTS-1:0]                   cl_req_valid,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0]        cl_req_addr,
    input  logic [N_CLIENTS*CLIENT_MDATA_WIDTH-1:0] cl_req_mdata,
    output logic [N_CLIENTS-1:0]                   cl_req_grant,
    output logic                                   mpf_c0_req_valid,
    output logic [ADDR_WIDTH-1:0]                  mpf_c0_req_addr,
    output logic [15:0]                            mpf_c0_req_mdata,
    input  logic                                   mpf_c0_almost_full,
    input  logic                                   mpf_c0_rsp_valid,
    input  logic                                   mpf_c0_rsp_eop,
    input  logic [15:0]                            mpf_c0_rsp_mdata,
    output logic [N_CLIENTS-1:0]                   cl_rsp_valid,
    output logic [CLIENT_MDATA_WIDTH-1:0]          cl_rsp_mdata,
    output logic                                   err_credit_underflow
`ifdef CCI_MPF_RD_ARB_STATS_EN
    ,
    output logic [N_CLIENTS*32-1:0]                stat_grants,
    output logic [31:0]                            stat_af_stall
`endif
);

    localparam int unsigned IDX_W = $clog2(N_CLIENTS);

    logic [N_CLIENTS-1:0] eligible_c;
    logic [N_CLIENTS-1:0] grant_c;
    logic [N_CLIENTS-1:0] eop_done_c;
    logic [IDX_W-1:0]     win_c;
    logic                 win_valid_c;
    logic [IDX_W-1:0]     rsp_idx_c;
    logic                 rsp_idx_ok_c;
    logic                 underflow_c;
    logic                 unused_rsp_bits;

    credit_t               cnt_q [N_CLIENTS];
    credit_t               cnt_d [N_CLIENTS];
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    mdata_t                req_mdata_q, req_mdata_d;
    logic                  err_q;

    // Eligibility uses registered credits; almost-full and reset block all grants
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            eligible_c[i] = cl_req_valid[i] && (cnt_q[i] < credit_t'(MAX_ACTIVE_PER_CLIENT))
                            && !mpf_c0_almost_full && !reset;
        end
    end

    cci_mpf_rr_arbiter #(.N(N_CLIENTS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (eligible_c),
        .grant_o     (grant_c),
        .win_o       (win_c),
        .win_valid_o (win_valid_c)
    );

    assign cl_req_grant = grant_c;

    // Response steering by the client index carried in the low Mdata bits
    assign rsp_idx_c       = mpf_c0_rsp_mdata[IDX_W-1:0];
    assign rsp_idx_ok_c    = 32'(client_idx_t'(rsp_idx_c)) < N_CLIENTS;
    assign cl_rsp_mdata    = mpf_c0_rsp_mdata[IDX_W +: CLIENT_MDATA_WIDTH];
    assign unused_rsp_bits = ^mpf_c0_rsp_mdata[15:IDX_W+CLIENT_MDATA_WIDTH];

    always_comb begin
        cl_rsp_valid = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            cl_rsp_valid[i] = mpf_c0_rsp_valid && rsp_idx_ok_c
                              && (rsp_idx_c == IDX_W'(i)) && !reset;
        end
    end

    // Credit update: grant adds one, eop removes one unless already empty
    always_comb begin
        underflow_c = mpf_c0_rsp_valid && !rsp_idx_ok_c;
        eop_done_c  = '0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            eop_done_c[i] = cl_rsp_valid[i] && mpf_c0_rsp_eop;
            if (eop_done_c[i] && (cnt_q[i] == '0)) begin
                underflow_c = 1'b1;
            end
            cnt_d[i] = cnt_q[i] + credit_t'(grant_c[i])
                       - credit_t'(eop_done_c[i] && (cnt_q[i] != '0));
        end
    end

    // Winning request payload; index rides in the low Mdata bits
    always_comb begin
        req_addr_d  = req_addr_q;
        req_mdata_d = req_mdata_q;
        if (win_valid_c) begin
            req_addr_d  = cl_req_addr[32'(win_c)*ADDR_WIDTH +: ADDR_WIDTH];
            req_mdata_d = (mdata_t'(cl_req_mdata[32'(win_c)*CLIENT_MDATA_WIDTH +: CLIENT_MDATA_WIDTH])
                           << IDX_W) | mdata_t'(win_c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                cnt_q[i] <= '0;
            end
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_mdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            req_valid_q <= win_valid_c;
            req_addr_q  <= req_addr_d;
            req_mdata_q <= req_mdata_d;
            err_q       <= err_q | underflow_c;
        end
    end

    assign mpf_c0_req_valid     = req_valid_q;
    assign mpf_c0_req_addr      = req_addr_q;
    assign mpf_c0_req_mdata     = req_mdata_q;
    assign err_credit_underflow = err_q;

`ifdef CCI_MPF_RD_ARB_STATS_EN
    logic [N_CLIENTS*32-1:0] stat_grants_q;
    logic [31:0]             stat_af_stall_q;

    // Free-running statistics, wrapping at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants_q   <= '0;
            stat_af_stall_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                stat_grants_q[i*32 +: 32] <= stat_grants_q[i*32 +: 32] + 32'(grant_c[i]);
            end
            stat_af_stall_q <= stat_af_stall_q + 32'((|cl_req_valid) && mpf_c0_almost_full);
        end
    end

    assign stat_grants   = stat_grants_q;
    assign stat_af_stall = stat_af_stall_q;
`endif

endmodule

// File: tb/tb_cci_mpf_rd_arb.sv
// Self-checking bench for cci_mpf_rd_arb (4 clients, credit limit 4).
// A credit/round-robin reference model predicts grants, steering and the
// registered request; directed scenarios are followed by a random phase.
module tb_cci_mpf_rd_arb;

    localparam int N   = 4;
    localparam int MAX = 4;
    localparam int AW  = 42;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      vld;
    logic [AW-1:0]     a [N];
    logic [7:0]        m [N];
    logic              af, rv, reop;
    logic [15:0]       rmd;

    logic [N-1:0]      cl_req_grant;
    logic              mpf_c0_req_valid;
    logic [AW-1:0]     mpf_c0_req_addr;
    logic [15:0]       mpf_c0_req_mdata;
    logic [N-1:0]      cl_rsp_valid;
    logic [7:0]        cl_rsp_mdata;
    logic              err_credit_underflow;

    always #5 clk = ~clk;

    cci_mpf_rd_arb #(
        .N_CLIENTS(N), .MAX_ACTIVE_PER_CLIENT(MAX), .ADDR_WIDTH(AW), .CLIENT_MDATA_WIDTH(8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cl_req_valid         (vld),
        .cl_req_addr          ({a[3], a[2], a[1], a[0]}),
        .cl_req_mdata         ({m[3], m[2], m[1], m[0]}),
        .cl_req_grant         (cl_req_grant),
        .mpf_c0_req_valid     (mpf_c0_req_valid),
        .mpf_c0_req_addr      (mpf_c0_req_addr),
        .mpf_c0_req_mdata     (mpf_c0_req_mdata),
        .mpf_c0_almost_full   (af),
        .mpf_c0_rsp_valid     (rv),
        .mpf_c0_rsp_eop       (reop),
        .mpf_c0_rsp_mdata     (rmd),
        .cl_rsp_valid         (cl_rsp_valid),
        .cl_rsp_mdata         (cl_rsp_mdata),
        .err_credit_underflow (err_credit_underflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            mcnt [N];
    int            mlast;
    logic          mval, merr;
    logic [AW-1:0] maddr;
    logic [15:0]   mmd;
    logic [N-1:0]  gcap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        mlast = N - 1;
        mval  = 1'b0;
        maddr = '0;
        mmd   = '0;
        merr  = 1'b0;
    endtask

    function automatic int pick();
        for (int o = 1; o <= N; o++) begin
            int p;
            p = (mlast + o) % N;
            if (vld[p] && mcnt[p] < MAX && !af) return p;
        end
        return -1;
    endfunction

    task automatic idle();
        vld = '0; af = 1'b0; rv = 1'b0; reop = 1'b0; rmd = '0;
    endtask

    task automatic rsp(input int idx, input logic eop, input logic [7:0] tag);
        rv = 1'b1; reop = eop; rmd = 16'({tag, 2'(idx)});
    endtask

    // One clock: check combinational outputs, then registered ones after the edge
    task automatic step();
        int g, idx;
        logic [N-1:0] eg, er;
        #1;
        g   = reset ? -1 : pick();
        idx = int'(rmd[1:0]);
        eg  = (g >= 0) ? N'(1 << g) : '0;
        er  = (rv && !reset) ? N'(1 << idx) : '0;
        gcap = cl_req_grant;
        chk("grant", 64'(cl_req_grant), 64'(eg));
        chk("rsp_valid", 64'(cl_rsp_valid), 64'(er));
        chk("rsp_mdata", 64'(cl_rsp_mdata), 64'(rmd[9:2]));
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (rv && reop) begin
                if (mcnt[idx] == 0) merr = 1'b1;
                else mcnt[idx]--;
            end
            if (g >= 0) begin
                mcnt[g]++;
                mlast = g;
                mval  = 1'b1;
                maddr = a[g];
                mmd   = 16'({m[g], 2'(g)});
            end else begin
                mval = 1'b0;
            end
        end
        chk("req_valid", 64'(mpf_c0_req_valid), 64'(mval));
        chk("req_addr", 64'(mpf_c0_req_addr), 64'(maddr));
        chk("req_mdata", 64'(mpf_c0_req_mdata), 64'(mmd));
        chk("err", 64'(err_credit_underflow), 64'(merr));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) begin
            while (mcnt[i] > 0) begin
                idle();
                rsp(i, 1'b1, 8'(i));
                step();
            end
        end
        idle();
    endtask

    initial begin
        logic [N-1:0] rr_seq [5];
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        for (int i = 0; i < N; i++) begin
            a[i] = AW'(64'h100 * (i + 1));
            m[i] = 8'(8'h10 + i);
        end
        model_reset();
        idle();

        // Reset: outputs quiet even with requests and a response present
        vld = '1;
        rsp(1, 1'b1, 8'h33);
        step();
        @(negedge clk);
        reset = 1'b0;
        idle();
        step();

        // Round robin 0,1,2,3,0 with all clients requesting
        vld = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", 64'(gcap), 64'(rr_seq[k]));
        end
        drain();

        // Client 2 alone: four grants, then blocked until an eop frees a credit
        vld = 4'b0100;
        for (int k = 0; k < 6; k++) step();
        chk("c2_blocked", 64'(gcap), 64'(0));
        rsp(2, 1'b1, 8'h00);
        step();
        rv = 1'b0; reop = 1'b0;
        step();
        chk("c2_resume", 64'(gcap), 64'(4'b0100));
        drain();

        // Almost-full for 10 cycles with everyone requesting
        vld = '1; af = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("af_nogrant", 64'(gcap), 64'(0));
            if (k >= 1) chk("af_req_low", 64'(mpf_c0_req_valid), 64'(0));
        end
        af = 1'b0;
        step();
        drain();

        // Client 1 at the limit; eop in the same cycle as the request
        vld = 4'b0010;
        for (int k = 0; k < MAX; k++) step();
        rsp(1, 1'b1, 8'h00);
        step();
        chk("c1_same_cycle", 64'(gcap), 64'(0));
        rv = 1'b0; reop = 1'b0;
        step();
        chk("c1_next", 64'(gcap), 64'(4'b0010));
        step();
        chk("c1_full_again", 64'(gcap), 64'(0));
        drain();

        // Four-beat response for client 3, tag A5
        vld = 4'b1000;
        step();
        vld = '0;
        for (int b = 0; b < 4; b++) begin
            rsp(3, (b == 3), 8'hA5);
            step();
            chk("beat_mdata", 64'(cl_rsp_mdata), 64'(8'hA5));
        end
        idle();
        step();

        // Random traffic; eops only for clients with outstanding reads
        for (int k = 0; k < 400; k++) begin
            int ri;
            vld = N'($urandom);
            af  = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                a[i] = AW'({$urandom, $urandom});
                m[i] = 8'($urandom);
            end
            ri   = int'($urandom_range(0, N - 1));
            rv   = ($urandom_range(0, 1) == 1);
            reop = rv && (mcnt[ri] > 0) && ($urandom_range(0, 1) == 1);
            rmd  = 16'({8'($urandom), 2'(ri)});
            step();
        end
        drain();

        // Underflow: eop for client 0 with nothing outstanding, sticky
        rsp(0, 1'b1, 8'h5A);
        step();
        idle();
        for (int k = 0; k < 3; k++) step();
        chk("err_sticky", 64'(err_credit_underflow), 64'(1));

        // Reset clears the sticky error
        reset = 1'b1;
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("err_cleared", 64'(err_credit_underflow), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
